// File: rtl/led_matrix_scanner_if.sv
// Frame-source / LED-driver bundle for led_matrix_scanner.
// Ports: red_in/green_in 16x16 row-major frames, frame_valid/frame_ack capture
// handshake, row_sel/red_col/green_col panel drive, frame_done end-of-frame pulse.
interface led_matrix_scanner_if;
  logic [15:0][15:0] red_in;
  logic [15:0][15:0] green_in;
  logic              frame_valid;
  logic              frame_ack;
  logic [15:0]       row_sel;
  logic [15:0]       red_col;
  logic [15:0]       green_col;
  logic              frame_done;

  // Frame producer / panel observer side.
  modport master (
    output red_in, green_in, frame_valid,
    input  frame_ack, row_sel, red_col, green_col, frame_done
  );

  // Scanner side.
  modport slave (
    input  red_in, green_in, frame_valid,
    output frame_ack, row_sel, red_col, green_col, frame_done
  );
endinterface

// File: rtl/led_matrix_scanner.sv
// Purpose: double-buffered 16x16 red/green LED matrix row scanner.
// Latency: frame_ack 1 cycle after capture; first row drive 1 cycle after ack.
// Backpressure: none; frame_valid held high re-captures every 2nd cycle, newest wins.
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      synchronous active-low reset
//   bus.slave  red_in/green_in/frame_valid in; frame_ack, row_sel, red_col,
//              green_col, frame_done out (all registered)
// Build option: define LED_MATRIX_SCANNER_BLANKING_EN to insert one dark
// BLANK cycle after every row (frame period 16*(DWELL_CYCLES+1) instead of
// 16*DWELL_CYCLES).
module led_matrix_scanner #(
  parameter int DWELL_CYCLES = 1000  // cycles each row is lit, 2..65535
) (
  input logic           clk,
  input logic           reset,
  led_matrix_scanner_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
`ifdef LED_MATRIX_SCANNER_BLANKING_EN
  localparam logic [1:0] BLANK = 2'd2;
`endif

  // Counter is loaded with DWELL-1 and the row ends when it reaches 0.
  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);

  logic [1:0]        state;
  logic [3:0]        row;
  logic [15:0]       dwell;

  logic [15:0][15:0] pend_red;
  logic [15:0][15:0] pend_green;
  logic              pend_full;
  logic [15:0][15:0] act_red;
  logic [15:0][15:0] act_green;

  logic              cap_prev;

  logic              frame_ack_q;
  logic              frame_done_q;
  logic [15:0]       row_sel_q;
  logic [15:0]       red_col_q;
  logic [15:0]       green_col_q;

  // Combinational control
  logic              cap_now;
  logic              dwell_end;
  logic              at_boundary;  // this edge starts row 0 of a new frame
  logic              load_en;      // this edge starts driving a row
  logic [3:0]        load_row;
  logic              swap_en;      // this edge replaces the active frame
  logic [15:0][15:0] src_red;      // frame the loaded row is taken from
  logic [15:0][15:0] src_green;

  always_comb begin
    cap_now   = bus.frame_valid & ~cap_prev;
    dwell_end = (dwell == 16'd0);

`ifdef LED_MATRIX_SCANNER_BLANKING_EN
    // Row was already advanced on entry to BLANK; row 0 here means wrap.
    at_boundary = (state == BLANK) && (row == 4'd0);
    load_en     = (state == BLANK);
    load_row    = row;
`else
    at_boundary = (state == SCAN) && dwell_end && (row == 4'd15);
    load_en     = (state == SCAN) && dwell_end;
    load_row    = row + 4'd1;
`endif

    if ((state == IDLE) && pend_full) begin
      load_en  = 1'b1;
      load_row = 4'd0;
    end

    swap_en   = 1'b0;
    src_red   = act_red;
    src_green = act_green;
    if (state == IDLE) begin
      if (pend_full) begin
        swap_en   = 1'b1;
        src_red   = pend_red;
        src_green = pend_green;
      end
    end else if (at_boundary) begin
      // A capture landing exactly on the frame boundary goes straight to the
      // active store so it is shown from row 0 of this frame, not one later.
      if (cap_now) begin
        swap_en   = 1'b1;
        src_red   = bus.red_in;
        src_green = bus.green_in;
      end else if (pend_full) begin
        swap_en   = 1'b1;
        src_red   = pend_red;
        src_green = pend_green;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      row          <= 4'd0;
      dwell        <= 16'd0;
      pend_red     <= '0;
      pend_green   <= '0;
      pend_full    <= 1'b0;
      act_red      <= '0;
      act_green    <= '0;
      cap_prev     <= 1'b0;
      frame_ack_q  <= 1'b0;
      frame_done_q <= 1'b0;
      row_sel_q    <= 16'd0;
      red_col_q    <= 16'd0;
      green_col_q  <= 16'd0;
    end else begin
      cap_prev    <= cap_now;
      frame_ack_q <= cap_now;

      // Registered, so set one cycle early to land on the last dwell cycle
      // of row 15 (DWELL_CYCLES >= 2 guarantees the counter passes 1).
      frame_done_q <= (state == SCAN) && (row == 4'd15) && (dwell == 16'd1);

      if (swap_en) begin
        act_red   <= src_red;
        act_green <= src_green;
      end

      // A boundary capture is consumed by the swap above, so it never
      // leaves pending marked full.
      if (cap_now) begin
        pend_red   <= bus.red_in;
        pend_green <= bus.green_in;
        pend_full  <= ~at_boundary;
      end else if (swap_en) begin
        pend_full  <= 1'b0;
      end

      if (load_en) begin
        state       <= SCAN;
        row         <= load_row;
        dwell       <= DWELL_LAST;
        row_sel_q   <= 16'd1 << load_row;
        red_col_q   <= src_red[load_row];
        green_col_q <= src_green[load_row];
      end else if (state == SCAN) begin
        if (dwell_end) begin
`ifdef LED_MATRIX_SCANNER_BLANKING_EN
          state       <= BLANK;
          row         <= row + 4'd1;
          row_sel_q   <= 16'd0;
          red_col_q   <= 16'd0;
          green_col_q <= 16'd0;
`endif
        end else begin
          dwell <= dwell - 16'd1;
        end
      end
    end
  end

  assign bus.frame_ack  = frame_ack_q;
  assign bus.frame_done = frame_done_q;
  assign bus.row_sel    = row_sel_q;
  assign bus.red_col    = red_col_q;
  assign bus.green_col  = green_col_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner with DWELL_CYCLES=4.
// Stimulus pushes per-cycle expected panel outputs; a negedge monitor pops
// and compares whenever an expectation for the current cycle is queued.
module tb_led_matrix_scanner;

  localparam int D = 4;
`ifdef LED_MATRIX_SCANNER_BLANKING_EN
  localparam int R = D + 1;  // cycles per row slot including blank
`else
  localparam int R = D;
`endif

  logic clk = 1'b0;
  logic reset;

  led_matrix_scanner_if bus();

  led_matrix_scanner #(.DWELL_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic        ack;
    logic        done;
    logic [15:0] rs;
    logic [15:0] rc;
    logic [15:0] gc;
  } exp_t;

  exp_t sbq[$];
  int   ack_at[$];
  int   checks = 0;
  int   fails  = 0;

  logic [15:0][15:0] fr_red [4];
  logic [15:0][15:0] fr_grn [4];

  function automatic bit is_ack(int c);
    foreach (ack_at[i]) if (ack_at[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_dark(int c0, int c1);
    for (int c = c0; c <= c1; c++) begin
      exp_t e;
      e.c = c; e.ack = is_ack(c); e.done = 1'b0;
      e.rs = 16'd0; e.rc = 16'd0; e.gc = 16'd0;
      sbq.push_back(e);
    end
  endtask

  // One frame of fi starting at cycle f0; expectations at or past stop_c dropped.
  task automatic push_frame(int f0, int fi, int stop_c);
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < R; k++) begin
        exp_t e;
        e.c   = f0 + r * R + k;
        if (e.c >= stop_c) return;
        e.ack = is_ack(e.c);
        if (k < D) begin
          e.rs   = 16'd1 << r;
          e.rc   = fr_red[fi][r];
          e.gc   = fr_grn[fi][r];
          e.done = (r == 15) && (k == D - 1);
        end else begin
          e.rs = 16'd0; e.rc = 16'd0; e.gc = 16'd0; e.done = 1'b0;
        end
        sbq.push_back(e);
      end
    end
  endtask

  task automatic goto(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(int fi);
    bus.red_in      = fr_red[fi];
    bus.green_in    = fr_grn[fi];
    bus.frame_valid = 1'b1;
  endtask

  task automatic drop_frame();
    bus.frame_valid = 1'b0;
    bus.red_in      = {16{16'hDEAD}};
    bus.green_in    = {16{16'hBEEF}};
  endtask

  // Monitor
  always @(negedge clk) begin : mon
    exp_t e;
    while (sbq.size() > 0 && sbq[0].c < cyc) begin
      e = sbq.pop_front();
      checks++;
      fails++;
      $display("FAIL missed_cycle: expectation for cycle %0d not sampled, now %0d", e.c, cyc);
    end
    if (sbq.size() > 0 && sbq[0].c == cyc) begin
      e = sbq.pop_front();
      checks++;
      if ({bus.frame_ack, bus.frame_done, bus.row_sel, bus.red_col, bus.green_col} !==
          {e.ack, e.done, e.rs, e.rc, e.gc}) begin
        fails++;
        $display("FAIL outputs cycle %0d: got ack=%b done=%b row=%h red=%h grn=%h, want ack=%b done=%b row=%h red=%h grn=%h",
                 cyc, bus.frame_ack, bus.frame_done, bus.row_sel, bus.red_col, bus.green_col,
                 e.ack, e.done, e.rs, e.rc, e.gc);
      end
    end
  end

  // Stimulus
  initial begin
    int f1, q, f2, f3, f4, dc, x, p2, f5, fin;

    for (int r = 0; r < 16; r++) begin
      fr_red[0][r] = 16'h00F0 + 16'(r) * 16'h1000;  // A: row 0 = 00F0
      fr_grn[0][r] = 16'h0F00 + 16'(r);             // A: row 0 = 0F00
      fr_red[1][r] = 16'hA000 | 16'(r);
      fr_grn[1][r] = 16'h0050 ^ (16'(r) << 8);
      fr_red[2][r] = 16'd1 << r;
      fr_grn[2][r] = ~(16'd1 << r);
      fr_red[3][r] = 16'h1234 ^ 16'(r);
      fr_grn[3][r] = 16'h4321;
    end

    f1  = 7;                  // A captured at edge 6, row 0 shown from 7
    q   = f1 + 7 * R + 1;     // B captured during row 7 of first A frame
    f2  = f1 + 16 * R;        // B shown
    f3  = f2 + 16 * R;        // B redisplayed
    f4  = f3 + 16 * R;        // C captured on the boundary edge itself
    dc  = f4 + 2 * R + 1;     // D captured, later discarded by reset
    x   = f4 + 5 * R + 1;     // reset on 2nd cycle of row 5
    p2  = x + 12;             // fresh A capture after reset
    f5  = p2 + 1;
    fin = f5 + 2 * R;

    ack_at = '{6, q, f4, dc, p2};

    // Reset held low with frame_valid high: nothing captured, all dark.
    reset = 1'b0;
    drive_frame(0);
    push_dark(1, 6);
    push_frame(f1, 0, f2);
    push_frame(f2, 1, f3);
    push_frame(f3, 1, f4);
    push_frame(f4, 2, x);
    push_dark(x, p2);
    push_frame(f5, 0, fin);

    goto(3);  reset = 1'b1; bus.frame_valid = 1'b0;
    goto(5);  drive_frame(0);
    goto(6);  drop_frame();
    goto(q - 1);  drive_frame(1);
    goto(q);      drop_frame();
    goto(f4 - 1); drive_frame(2);
    goto(f4);     drop_frame();
    goto(dc - 1); drive_frame(3);
    goto(dc);     drop_frame();
    goto(x - 1);  reset = 1'b0;
    goto(x + 1);  reset = 1'b1;
    goto(p2 - 1); drive_frame(0);
    goto(p2);     drop_frame();
    goto(fin + 2);

    checks++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: time limit reached at cycle %0d, want finish before it", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
